// File: rtl/game_ctrl_pkg.sv
// Shared types and constants for the game sequencer: FSM state encoding,
// VGA screen-mux codes and the game-select width helper.
package game_ctrl_pkg;

  // Top-level sequencer states. StPause is only reachable when the pause
  // feature is built in.
  typedef enum logic [2:0] {
    StMenu,
    StLaunch,
    StPlay,
    StWinHold,
    StLoseHold,
    StWinWait,
    StLoseWait,
    StPause
  } state_e;

  // Screen-mux select codes seen by the VGA block.
  localparam logic [2:0] ScrMenu  = 3'd0;
  localparam logic [2:0] ScrPlay  = 3'd1;
  localparam logic [2:0] ScrWin   = 3'd2;
  localparam logic [2:0] ScrLose  = 3'd3;
  localparam logic [2:0] ScrPause = 3'd4;

  // Width of the game index: clog2 of the game count, never below one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/game_tick_gen.sv
// Auto-drop tick generator. The tick period shrinks with the level down to
// a floor; a new period is only picked up when the counter restarts, so a
// level change never shortens the drop already in progress.
module game_tick_gen
  import game_ctrl_pkg::*;
#(
  parameter int unsigned TICK_BASE = 50000000,
  parameter int unsigned TICK_STEP = 4000000,
  parameter int unsigned TICK_MIN  = 5000000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       clear,   // synchronous restart with a freshly computed period
  input  logic       enable,  // counter runs while high
  input  logic       freeze,  // holds the counter and masks the tick
  input  logic [3:0] level,
  output logic       tick
);

  // A zero period would make period-1 wrap; treat it as one.
  localparam int unsigned MinPeriod  = (TICK_MIN == 0) ? 1 : TICK_MIN;
  localparam int unsigned BasePeriod = (TICK_BASE > MinPeriod) ? TICK_BASE : MinPeriod;

  logic [35:0] step_total;
  logic [31:0] period_lvl;
  logic [31:0] period_q;
  logic [31:0] count_q;
  logic        run;
  logic        wrap;

  // Level-scaled period, clamped before the subtraction so it cannot underflow.
  always_comb begin
    step_total = 36'(level) * 36'(TICK_STEP);
    period_lvl = MinPeriod;
    if (BasePeriod > MinPeriod) begin
      if (step_total < 36'(BasePeriod - MinPeriod)) begin
        period_lvl = BasePeriod - step_total[31:0];
      end
    end
  end

  assign run  = enable & ~freeze;
  assign wrap = (count_q == period_q - 32'd1);
  assign tick = run & wrap;

  // Counter and latched period.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q  <= '0;
      period_q <= BasePeriod;
    end else if (clear) begin
      count_q  <= '0;
      period_q <= period_lvl;
    end else if (run) begin
      if (wrap) begin
        count_q  <= '0;
        period_q <= period_lvl;
      end else begin
        count_q <= count_q + 32'd1;
      end
    end
  end

endmodule

// File: rtl/game_mode_ctrl.sv
// Top-level game sequencer: menu selection among NUM_GAMES cores, launch
// handshake, level-scaled auto-drop ticks and blinking win/lose screens.
// Optional pause chord (left+right) is built when GAME_MODE_CTRL_PAUSE_EN
// is defined; the default build has no pause state and no pause_out port.
module game_mode_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int unsigned NUM_GAMES    = 3,
  parameter int unsigned TICK_BASE    = 50000000,
  parameter int unsigned TICK_STEP    = 4000000,
  parameter int unsigned TICK_MIN     = 5000000,
  parameter int unsigned MAX_LEVEL    = 9,
  parameter int unsigned BLINK_PERIOD = 25000000,
  parameter int unsigned HOLD_CYCLES  = 50000000,
  localparam int unsigned SEL_W       = sel_w(NUM_GAMES)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             key_u,
  input  logic             key_d,
  input  logic             key_l,
  input  logic             key_r,
  input  logic             game_over,
  input  logic             game_win,
  input  logic             level_up,
  output logic [SEL_W-1:0] game_sel,
  output logic             game_start,
  output logic             game_run,
  output logic             tick,
  output logic [3:0]       level,
  output logic             blink,
`ifdef GAME_MODE_CTRL_PAUSE_EN
  output logic             pause_out,
`endif
  output logic [2:0]       screen
);

  localparam int unsigned HoldLast  = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
  localparam int unsigned BlinkLast = (BLINK_PERIOD > 0) ? BLINK_PERIOD - 1 : 0;
  localparam logic [3:0]  LevelMax  = 4'(MAX_LEVEL);

  state_e      state_q;
  logic [31:0] hold_cnt_q;
  logic [31:0] blink_cnt_q;

  logic [3:0]  keys;
  logic [3:0]  key_q;
  logic        hist_valid_q;
  logic [3:0]  press;
  logic        press_u;
  logic        press_d;
  logic        press_l;
  logic        press_r;

  logic [SEL_W-1:0] sel_inc;
  logic [SEL_W-1:0] sel_dec;
  logic             end_state;
  logic             tick_clear;
  logic             tick_enable;
  logic             paused;

  // Key history. hist_valid_q keeps a key that is already held when reset
  // releases from counting as a press: the first cycle only records levels.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      key_q        <= '0;
      hist_valid_q <= 1'b0;
    end else begin
      key_q        <= keys;
      hist_valid_q <= 1'b1;
    end
  end

  assign keys    = {key_u, key_d, key_l, key_r};
  assign press   = keys & ~key_q & {4{hist_valid_q}};
  assign press_u = press[3];
  assign press_d = press[2];
  assign press_l = press[1];
  assign press_r = press[0];

  // Wrapping neighbours of the current selection.
  always_comb begin
    sel_inc = (game_sel == SEL_W'(NUM_GAMES - 1)) ? '0 : game_sel + SEL_W'(1);
    sel_dec = (game_sel == '0) ? SEL_W'(NUM_GAMES - 1) : game_sel - SEL_W'(1);
  end

  assign end_state = (state_q == StWinHold) || (state_q == StLoseHold) ||
                     (state_q == StWinWait) || (state_q == StLoseWait);

`ifdef GAME_MODE_CTRL_PAUSE_EN
  assign paused = (state_q == StPause);
`else
  assign paused = 1'b0;
`endif

  assign tick_clear  = (state_q == StLaunch);
  assign tick_enable = (state_q == StPlay) || paused;

  game_tick_gen #(
    .TICK_BASE (TICK_BASE),
    .TICK_STEP (TICK_STEP),
    .TICK_MIN  (TICK_MIN)
  ) u_tick_gen (
    .clk    (clk),
    .clr    (clr),
    .clear  (tick_clear),
    .enable (tick_enable),
    .freeze (paused),
    .level  (level),
    .tick   (tick)
  );

  // Sequencer FSM with registered outputs, hold timer and blink timer.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= StMenu;
      game_sel    <= '0;
      game_start  <= 1'b0;
      game_run    <= 1'b0;
      level       <= '0;
      blink       <= 1'b0;
      screen      <= ScrMenu;
      hold_cnt_q  <= '0;
      blink_cnt_q <= '0;
`ifdef GAME_MODE_CTRL_PAUSE_EN
      pause_out   <= 1'b0;
`endif
    end else begin
      game_start <= 1'b0;

      // Blink free-runs on the end screens; a later MENU entry overrides it.
      if (end_state) begin
        if (blink_cnt_q == BlinkLast) begin
          blink_cnt_q <= '0;
          blink       <= ~blink;
        end else begin
          blink_cnt_q <= blink_cnt_q + 32'd1;
        end
      end

      unique case (state_q)
        StMenu: begin
          if (press_r) begin
            // Level cleared here so the tick generator sees level 0 during LAUNCH.
            state_q    <= StLaunch;
            game_start <= 1'b1;
            level      <= '0;
          end else if (press_d && !press_u) begin
            game_sel <= sel_inc;
          end else if (press_u && !press_d) begin
            game_sel <= sel_dec;
          end
        end

        StLaunch: begin
          state_q  <= StPlay;
          game_run <= 1'b1;
          screen   <= ScrPlay;
          level    <= '0;
        end

        StPlay: begin
          if (level_up && (level < LevelMax)) begin
            level <= level + 4'd1;
          end
          if (game_over) begin
            state_q    <= StLoseHold;
            screen     <= ScrLose;
            game_run   <= 1'b0;
            hold_cnt_q <= '0;
          end else if (game_win) begin
            state_q    <= StWinHold;
            screen     <= ScrWin;
            game_run   <= 1'b0;
            hold_cnt_q <= '0;
          end
`ifdef GAME_MODE_CTRL_PAUSE_EN
          else if (press_l && press_r) begin
            state_q   <= StPause;
            screen    <= ScrPause;
            game_run  <= 1'b0;
            pause_out <= 1'b1;
          end
`endif
        end

        StWinHold, StLoseHold: begin
          // Keys are ignored until the lockout expires.
          if (hold_cnt_q == HoldLast) begin
            state_q <= (state_q == StWinHold) ? StWinWait : StLoseWait;
          end else begin
            hold_cnt_q <= hold_cnt_q + 32'd1;
          end
        end

        StWinWait, StLoseWait: begin
          if (|press) begin
            state_q     <= StMenu;
            screen      <= ScrMenu;
            blink       <= 1'b0;
            blink_cnt_q <= '0;
          end
        end

`ifdef GAME_MODE_CTRL_PAUSE_EN
        StPause: begin
          // Tick counter is frozen in the generator; resuming keeps its value.
          if (press_l && press_r) begin
            state_q   <= StPlay;
            screen    <= ScrPlay;
            game_run  <= 1'b1;
            pause_out <= 1'b0;
          end
        end
`endif

        default: begin
          state_q  <= StMenu;
          screen   <= ScrMenu;
          game_run <= 1'b0;
        end
      endcase
    end
  end

  // Only the chord uses the left key; without pause it is otherwise unused.
`ifndef GAME_MODE_CTRL_PAUSE_EN
  logic unused_press_l;
  assign unused_press_l = press_l;
`endif

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Scoreboard bench for game_mode_ctrl: the stimulus pushes expected pulse
// cycles and output snapshots; a monitor pops and compares on falling edges.
module tb_game_mode_ctrl;

  logic       clk;
  logic       clr;
  logic       key_u, key_d, key_l, key_r;
  logic       game_over, game_win, level_up;
  logic [1:0] game_sel;
  logic       game_start, game_run, tick, blink;
  logic [3:0] level;
  logic [2:0] screen;
`ifdef GAME_MODE_CTRL_PAUSE_EN
  logic       pause_out;
`endif

  game_mode_ctrl #(
    .NUM_GAMES    (3),
    .TICK_BASE    (20),
    .TICK_STEP    (5),
    .TICK_MIN     (8),
    .MAX_LEVEL    (9),
    .BLINK_PERIOD (7),
    .HOLD_CYCLES  (30)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .key_u      (key_u),
    .key_d      (key_d),
    .key_l      (key_l),
    .key_r      (key_r),
    .game_over  (game_over),
    .game_win   (game_win),
    .level_up   (level_up),
    .game_sel   (game_sel),
    .game_start (game_start),
    .game_run   (game_run),
    .tick       (tick),
    .level      (level),
    .blink      (blink),
`ifdef GAME_MODE_CTRL_PAUSE_EN
    .pause_out  (pause_out),
`endif
    .screen     (screen)
  );

  // Observed bundle: sel[12:11] start[10] run[9] tick[8] level[7:4] blink[3] screen[2:0]
  localparam logic [12:0] MSel   = 13'h1800;
  localparam logic [12:0] MRun   = 13'h0200;
  localparam logic [12:0] MLvl   = 13'h00F0;
  localparam logic [12:0] MBlink = 13'h0008;
  localparam logic [12:0] MScr   = 13'h0007;
  localparam logic [12:0] MAll   = 13'h1FFF;

  typedef struct {
    string       name;
    logic [12:0] mask;
    logic [12:0] val;
  } snap_t;

  typedef struct {
    string name;
    int    at;
  } evt_t;

  snap_t snap_q[$];
  evt_t  start_q[$];
  evt_t  tick_q[$];

  int   cyc;
  int   checks;
  int   failures;
  logic final_chk;
  logic final_done;

  logic [12:0] obs;
  assign obs = {game_sel, game_start, game_run, tick, level, blink, screen};

  function automatic logic [12:0] mk(input logic [1:0] sel, input logic st, input logic run,
                                     input logic tk, input logic [3:0] lv, input logic bl,
                                     input logic [2:0] sc);
    return {sel, st, run, tk, lv, bl, sc};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pulses are matched against expected cycles, snapshots against masks.
  initial begin
    evt_t  e;
    snap_t s;
    forever begin
      @(negedge clk);
      if (game_start) begin
        checks = checks + 1;
        if (start_q.size() == 0) begin
          failures = failures + 1;
          $display("FAIL unexpected_start: pulse at cycle %0d, none expected", cyc);
        end else begin
          e = start_q.pop_front();
          if (e.at != cyc) begin
            failures = failures + 1;
            $display("FAIL %s: pulse at cycle %0d, expected cycle %0d", e.name, cyc, e.at);
          end
        end
      end
      if (tick) begin
        checks = checks + 1;
        if (tick_q.size() == 0) begin
          failures = failures + 1;
          $display("FAIL unexpected_tick: tick at cycle %0d, none expected", cyc);
        end else begin
          e = tick_q.pop_front();
          if (e.at != cyc) begin
            failures = failures + 1;
            $display("FAIL %s: tick at cycle %0d, expected cycle %0d", e.name, cyc, e.at);
          end
        end
      end
      while (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        checks = checks + 1;
        if ((obs & s.mask) !== s.val) begin
          failures = failures + 1;
          $display("FAIL %s: got %h, expected %h (mask %h) at cycle %0d",
                   s.name, obs & s.mask, s.val, s.mask, cyc);
        end
      end
      if (final_chk && !final_done) begin
        final_done = 1'b1;
        checks = checks + 2;
        if (start_q.size() != 0) begin
          failures = failures + 1;
          $display("FAIL missing_start: %0d start pulses never seen, expected 0", start_q.size());
        end
        if (tick_q.size() != 0) begin
          failures = failures + 1;
          $display("FAIL missing_tick: %0d ticks never seen, expected 0", tick_q.size());
        end
      end
    end
  end

  task automatic expect_snap(input string nm, input logic [12:0] m, input logic [12:0] v);
    snap_t s;
    s.name = nm;
    s.mask = m;
    s.val  = v & m;
    snap_q.push_back(s);
  endtask

  task automatic expect_start(input string nm, input int at);
    evt_t e;
    e.name = nm;
    e.at   = at;
    start_q.push_back(e);
  endtask

  task automatic expect_tick(input string nm, input int at);
    evt_t e;
    e.name = nm;
    e.at   = at;
    tick_q.push_back(e);
  endtask

  // All drives happen 1 time unit after a rising edge, where cyc is current.
  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle key tap {u,d,l,r} followed by an idle cycle.
  task automatic tap(input logic [3:0] k);
    {key_u, key_d, key_l, key_r} = k;
    @(posedge clk); #1;
    {key_u, key_d, key_l, key_r} = 4'b0000;
    @(posedge clk); #1;
  endtask

  task automatic press_at(input int t, input logic [3:0] k);
    wait_until(t);
    {key_u, key_d, key_l, key_r} = k;
    @(posedge clk); #1;
    {key_u, key_d, key_l, key_r} = 4'b0000;
  endtask

  task automatic pulse_level(input int t);
    wait_until(t);
    level_up = 1'b1;
    @(posedge clk); #1;
    level_up = 1'b0;
  endtask

  // Time limit: flag and stop rather than hang.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int e_cyc;
    int r;
    cyc = 0; checks = 0; failures = 0;
    final_chk = 1'b0; final_done = 1'b0;
    {key_u, key_d, key_l, key_r} = 4'b0000;
    game_over = 1'b0; game_win = 1'b0; level_up = 1'b0;
    clr = 1'b0;
    #1 clr = 1'b1;
    @(posedge clk); #1;
    expect_snap("reset_outputs", MAll, 13'h0000);
    @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Menu selection with wrap in both directions.
    tap(4'b0100); expect_snap("sel_d1", MSel, mk(2'd1, 0, 0, 0, 0, 0, 0));
    tap(4'b0100); expect_snap("sel_d2", MSel, mk(2'd2, 0, 0, 0, 0, 0, 0));
    tap(4'b0100); expect_snap("sel_d3_wrap", MSel, mk(2'd0, 0, 0, 0, 0, 0, 0));
    tap(4'b0100); expect_snap("sel_d4", MSel, mk(2'd1, 0, 0, 0, 0, 0, 0));
    tap(4'b1000); expect_snap("sel_u1", MSel, mk(2'd0, 0, 0, 0, 0, 0, 0));
    tap(4'b1000); expect_snap("sel_u_wrap", MSel | MScr, mk(2'd2, 0, 0, 0, 0, 0, 0));
    tap(4'b1100); expect_snap("sel_ud_hold", MSel | MScr, mk(2'd2, 0, 0, 0, 0, 0, 0));

    // Launch with r+d together: r wins, selection holds.
    c = cyc;
    expect_start("launch1_start", c + 1);
    expect_tick("tick_p20_a", c + 21);
    expect_tick("tick_p20_b", c + 41);
    expect_tick("tick_p15", c + 56);
    expect_tick("tick_p10", c + 66);
    for (int n = 0; n < 8; n++) expect_tick("tick_p8", c + 74 + 8 * n);
    tap(4'b0101);
    expect_snap("launch1_play", MAll, mk(2'd2, 0, 1, 0, 4'd0, 0, 3'd1));

    // Level speed-up and saturation.
    pulse_level(c + 25); expect_snap("level_1", MLvl, mk(0, 0, 0, 0, 4'd1, 0, 0));
    pulse_level(c + 45); expect_snap("level_2", MLvl, mk(0, 0, 0, 0, 4'd2, 0, 0));
    pulse_level(c + 60); expect_snap("level_3", MLvl, mk(0, 0, 0, 0, 4'd3, 0, 0));
    for (int n = 0; n < 20; n++) pulse_level(c + 76 + 2 * n);
    expect_snap("level_sat", MLvl | MScr | MRun, mk(0, 0, 1, 0, 4'd9, 0, 3'd1));

    // Win and lose together on a tick cycle: lose wins, tick still emitted.
    e_cyc = c + 130;
    wait_until(e_cyc);
    game_over = 1'b1; game_win = 1'b1;
    @(posedge clk); #1;
    game_over = 1'b0; game_win = 1'b0;
    expect_snap("lose_screen", MScr | MRun | MBlink, mk(0, 0, 0, 0, 0, 0, 3'd3));
    wait_until(e_cyc + 8);
    expect_snap("blink_on", MBlink | MScr, mk(0, 0, 0, 0, 0, 1, 3'd3));
    press_at(e_cyc + 11, 4'b1000);
    expect_snap("hold_press_ignored", MScr | MBlink, mk(0, 0, 0, 0, 0, 1, 3'd3));
    wait_until(e_cyc + 15);
    expect_snap("blink_off", MBlink | MScr, mk(0, 0, 0, 0, 0, 0, 3'd3));
    wait_until(e_cyc + 31);
    expect_snap("wait_screen", MBlink | MScr, mk(0, 0, 0, 0, 0, 0, 3'd3));
    wait_until(e_cyc + 36);
    expect_snap("wait_blink_runs", MBlink | MScr, mk(0, 0, 0, 0, 0, 1, 3'd3));
    press_at(e_cyc + 36, 4'b0100);
    expect_snap("wait_press_menu", MSel | MScr | MBlink | MRun, mk(2'd2, 0, 0, 0, 0, 0, 3'd0));
    wait_until(e_cyc + 45);
    expect_snap("menu_blink_frozen", MBlink | MScr, mk(0, 0, 0, 0, 0, 0, 3'd0));

    // Reset during PLAY with key_r held through the reset release.
    wait_until(e_cyc + 46);
    c = cyc;
    expect_start("launch2_start", c + 1);
    key_r = 1'b1;
    wait_until(c + 12);
    clr = 1'b1;
    #1;
    expect_snap("midplay_reset", MAll, 13'h0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clr = 1'b0;
    r = cyc;
    wait_until(r + 5);
    expect_snap("held_key_no_press", MAll, 13'h0000);
    key_r = 1'b0;
    wait_until(r + 7);
    c = cyc;
    expect_start("launch3_start", c + 1);
    tap(4'b0001);
    expect_snap("launch3_play", MAll, mk(2'd0, 0, 1, 0, 4'd0, 0, 3'd1));

    @(posedge clk); #1;
    final_chk = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
